// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and special cases at the boundaries.
module muldiv_iter #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_inp_rdy,
    input  logic [2:0]      md_funct3,
    input  logic [XLEN-1:0] md_rs1,
    input  logic [XLEN-1:0] md_rs2,
    input  logic            md_flush,
    output logic            md_busy,
    output logic            md_otp_rdy,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          f3_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN:0]       rem_q;
    logic                busy_q;
    logic                otp_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                sgn1, sgn2, neg_in;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf, fast_hit;
    logic [XLEN-1:0]     spec_res, fast_res;
    logic [2*XLEN-1:0]   fast_prod;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   acc_mul_nxt;
    logic [XLEN:0]       div_sh, rem_nxt;
    logic                div_ge;
    logic [XLEN-1:0]     quo_nxt, div_val, mul_res, div_res;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic low);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        return low ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        accept   = md_inp_rdy && !md_flush && (state_q == S_IDLE || state_q == S_DONE);
        sgn1     = md_rs1[XLEN-1] && (md_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
        sgn2     = md_rs2[XLEN-1] && (md_funct3 inside {3'b001, 3'b100, 3'b110});
        mag1     = sgn1 ? -md_rs1 : md_rs1;
        mag2     = sgn2 ? -md_rs2 : md_rs2;
        // Remainders follow the dividend sign; products and quotients the XOR of both.
        neg_in   = (md_funct3[2] && md_funct3[1]) ? sgn1 : (sgn1 ^ sgn2);

        div_zero = md_funct3[2] && (md_rs2 == '0);
        div_ovf  = md_funct3[2] && !md_funct3[0] && (md_rs2 == '1)
                   && (md_rs1 == {1'b1, {(XLEN-1){1'b0}}});
        spec_res = '0;
        if (div_zero)
            spec_res = md_funct3[1] ? md_rs1 : '1;
        else if (div_ovf)
            spec_res = md_funct3[1] ? '0 : md_rs1;

        fast_hit  = FAST_MUL && !md_funct3[2];
        fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_res  = mul_pick(fast_prod, neg_in, md_funct3 == 3'b000);

        // Multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
        mul_res     = mul_pick(acc_mul_nxt, neg_q, f3_q == 3'b000);

        div_sh  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_ge  = div_sh >= {1'b0, opb_q};
        rem_nxt = div_ge ? (div_sh - {1'b0, opb_q}) : div_sh;
        quo_nxt = {acc_q[XLEN-2:0], div_ge};
        div_val = f3_q[1] ? rem_nxt[XLEN-1:0] : quo_nxt;
        div_res = neg_q ? -div_val : div_val;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            otp_q    <= 1'b0;
            result_q <= '0;
        end else if (md_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            otp_q   <= 1'b0;
        end else begin
            otp_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        f3_q  <= md_funct3;
                        neg_q <= neg_in;
                        if (div_zero || div_ovf) begin
                            state_q  <= S_DONE;
                            otp_q    <= 1'b1;
                            result_q <= spec_res;
                        end else if (fast_hit) begin
                            state_q  <= S_DONE;
                            otp_q    <= 1'b1;
                            result_q <= fast_res;
                        end else begin
                            state_q <= md_funct3[2] ? S_DIV : S_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(XLEN);
                            opb_q   <= md_funct3[2] ? mag2 : mag1;
                            acc_q   <= {{XLEN{1'b0}}, (md_funct3[2] ? mag1 : mag2)};
                            rem_q   <= '0;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_mul_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        otp_q    <= 1'b1;
                        result_q <= mul_res;
                    end
                end
                S_DIV: begin
                    acc_q <= {{XLEN{1'b0}}, quo_nxt};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        otp_q    <= 1'b1;
                        result_q <= div_res;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign md_busy    = busy_q;
    assign md_otp_rdy = otp_q;
    assign md_result  = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (XLEN=32, FAST_MUL=0): latency, busy window, results,
// special cases, flush, back-to-back acceptance and asynchronous reset.
module tb_muldiv_iter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            md_inp_rdy;
    logic [2:0]      md_funct3;
    logic [XLEN-1:0] md_rs1;
    logic [XLEN-1:0] md_rs2;
    logic            md_flush;
    logic            md_busy;
    logic            md_otp_rdy;
    logic [XLEN-1:0] md_result;

    int n_total = 0;
    int n_bad   = 0;

    muldiv_iter #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_inp_rdy (md_inp_rdy),
        .md_funct3  (md_funct3),
        .md_rs1     (md_rs1),
        .md_rs2     (md_rs2),
        .md_flush   (md_flush),
        .md_busy    (md_busy),
        .md_otp_rdy (md_otp_rdy),
        .md_result  (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one request and follows it to its result pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        md_inp_rdy = 1'b1;
        md_funct3  = f3;
        md_rs1     = a;
        md_rs2     = b;
        @(posedge clk);
        @(negedge clk);
        md_inp_rdy = 1'b0;
        md_funct3  = 3'($urandom);
        md_rs1     = $urandom;
        md_rs2     = $urandom;
        for (int k = 1; k <= 100; k++) begin
            if (md_otp_rdy) begin
                lat = k;
                break;
            end
            if (md_busy) nbusy++;
            @(negedge clk);
        end
        check($sformatf("%s.lat", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s.res", tag), 64'(md_result), 64'(exp_res));
        check($sformatf("%s.busycyc", tag), 64'(nbusy), 64'(exp_lat - 1));
        check($sformatf("%s.busy_at_done", tag), 64'(md_busy), 64'(0));
    endtask

    initial begin
        int saw_otp;
        int first, second;
        logic [31:0] r1, r2;
        rst_n      = 1'b0;
        md_inp_rdy = 1'b0;
        md_funct3  = '0;
        md_rs1     = '0;
        md_rs2     = '0;
        md_flush   = 1'b0;
        #12;
        check("rst.busy", 64'(md_busy), 64'(0));
        check("rst.otp", 64'(md_otp_rdy), 64'(0));
        check("rst.res", 64'(md_result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk); run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        @(negedge clk); run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        @(negedge clk); run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        @(negedge clk); run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        @(negedge clk); run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        @(negedge clk); run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        @(negedge clk); run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        @(negedge clk); run_op("divu",   3'b101, 32'd7,        32'd2,        32'd3,        33);
        @(negedge clk); run_op("remu",   3'b111, 32'd7,        32'd2,        32'd1,        33);
        @(negedge clk); run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        @(negedge clk); run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        @(negedge clk); run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        @(negedge clk); run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);

        // Flush a DIVU in cycle 10, then issue MUL 3x4 in cycle 11.
        @(negedge clk);
        md_inp_rdy = 1'b1;
        md_funct3  = 3'b101;
        md_rs1     = 32'd100;
        md_rs2     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        md_inp_rdy = 1'b0;
        saw_otp = 0;
        for (int k = 1; k < 10; k++) begin
            if (md_otp_rdy) saw_otp = 1;
            @(negedge clk);
        end
        check("flush.busy_c10", 64'(md_busy), 64'(1));
        md_flush = 1'b1;
        md_inp_rdy = 1'b1;
        md_funct3  = 3'b000;
        md_rs1     = 32'd9;
        md_rs2     = 32'd9;
        @(negedge clk);
        md_flush = 1'b0;
        if (md_otp_rdy) saw_otp = 1;
        check("flush.no_otp", 64'(saw_otp), 64'(0));
        check("flush.busy_c11", 64'(md_busy), 64'(0));
        check("flush.res_kept", 64'(md_result), 64'(5));
        run_op("flush.mul", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Back-to-back: second request held through the DONE cycle.
        @(negedge clk);
        md_inp_rdy = 1'b1;
        md_funct3  = 3'b000;
        md_rs1     = 32'd5;
        md_rs2     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        md_funct3  = 3'b101;
        md_rs1     = 32'd100;
        md_rs2     = 32'd7;
        first = 0; second = 0; r1 = '0; r2 = '0;
        for (int k = 1; k <= 120; k++) begin
            if (md_otp_rdy) begin
                if (first == 0) begin
                    first = k;
                    r1 = md_result;
                end else if (second == 0) begin
                    second = k;
                    r2 = md_result;
                end
            end
            if (k == 34) md_inp_rdy = 1'b0;
            if (second != 0) break;
            @(negedge clk);
        end
        check("b2b.first_cyc", 64'(first), 64'(33));
        check("b2b.first_res", 64'(r1), 64'(30));
        check("b2b.second_cyc", 64'(second), 64'(66));
        check("b2b.second_res", 64'(r2), 64'(14));

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        md_inp_rdy = 1'b1;
        md_funct3  = 3'b100;
        md_rs1     = 32'hFFFFFFF9;
        md_rs2     = 32'd2;
        @(posedge clk);
        @(negedge clk);
        md_inp_rdy = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", 64'(md_busy), 64'(0));
        check("arst.otp", 64'(md_otp_rdy), 64'(0));
        check("arst.res", 64'(md_result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); run_op("post_rst", 3'b101, 32'd7, 32'd2, 32'd3, 33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) parametrised in data width. It replaces single-cycle combinational multiply and divide in the execute stage with a multi-cycle shift-add/shift-subtract datapath behind a ready/busy handshake. It also adds spec-exact divide-by-zero and signed-overflow results. The execute stage stalls on `md_busy`, writes `md_result` to `rd` on `md_otp_rdy`, and pulses `md_flush` on a taken jump.

## Interface
- XLEN, 32, operand/result width (>= 8).
- FAST_MUL, 0, when 1 multiplies complete in one cycle (single-cycle product registered); divides stay iterative.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- md_inp_rdy  in  1  request valid; accepted on an edge where `md_busy` is low and `md_flush` is low.
- md_funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- md_rs1  in  XLEN  operand 1 (dividend / multiplicand).
- md_rs2  in  XLEN  operand 2 (divisor / multiplier).
- md_flush  in  1  abort any in-flight operation.
- md_busy  out  1  high while an accepted operation is iterating.
- md_otp_rdy  out  1  one-cycle result-valid pulse.
- md_result  out  XLEN  result; holds its last value until the next completion.

## Operation
- States:
  - IDLE.
  - MUL: iterate.
  - DIV: iterate.
  - DONE: `md_otp_rdy`=1 for exactly one cycle.
- Accept in IDLE or DONE: operands and funct3 are latched and the iteration counter is loaded with XLEN.
- Signed handling: signed operands are converted to magnitudes at accept. The unsigned core runs on the magnitudes. The result is conditionally negated on entry to DONE.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign1.
- Operand signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU and DIVU/REMU: both unsigned.
- MUL datapath: 2*XLEN-bit accumulator, radix-2, one multiplier bit per cycle.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
- DIV datapath: restoring division, one quotient bit per cycle.
  - Remainder register is XLEN+1 bits.
- Special cases skip iteration and go IDLE/DONE -> DONE directly:
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - DIV with rs1 = most-negative and rs2 = -1: DIV -> most-negative; REM -> 0.
  - FAST_MUL=1 and a multiply op.
- Flush:
  - `md_flush`=1 sends the unit to IDLE on the next edge.
  - A request in the same cycle as the flush is ignored.
  - No `md_otp_rdy` is generated for the aborted op, and `md_result` is unchanged.
  - A `md_otp_rdy` already high in the flush cycle is not retracted.
- Reset (asynchronous, any state): state IDLE, `md_busy`=0, `md_otp_rdy`=0, `md_result`=0, counter 0.

## Timing
- Accepting edge = edge 0.
- Iterative op:
  - `md_busy`=1 for cycles 1..XLEN.
  - `md_otp_rdy`=1 and `md_result` valid in cycle XLEN+1, where `md_busy`=0.
  - Latency XLEN+1 (33 for XLEN=32).
- Special case / fast multiply: `md_otp_rdy` in cycle 1; `md_busy` never asserts.
- Back-to-back: a request accepted in the DONE cycle starts immediately, giving throughput of one op per XLEN+1 cycles.
- `md_busy`, `md_otp_rdy` and `md_result` are all registered; there are no combinational paths from inputs to outputs.
- Operand inputs are don't-care after the accepting edge.
- `md_inp_rdy` while `md_busy`=1 is ignored; the requester must hold it until accepted.

## Test plan
- MUL 7 x 0xFFFFFFFD (XLEN=32, FAST_MUL=0) -> `md_result`=0xFFFFFFEB, `md_otp_rdy` exactly in cycle 33, `md_busy` high in cycles 1..32.
- High products with rs1=rs2=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
  - MULHU -> 0xFFFFFFFE.
  - Also MULH 0x80000000 x 0x80000000 -> 0x40000000.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 7 / 2 -> 3.
  - REMU 7 / 2 -> 1.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - Each completes with `md_otp_rdy` in cycle 1 and `md_busy` never high.
- Flush:
  - Start DIVU, assert `md_flush` in cycle 10 -> no `md_otp_rdy`, `md_busy` low from cycle 11, `md_result` unchanged.
  - A request in cycle 11 (MUL 3x4) -> 12 in cycle 44.
- Back-to-back and reset:
  - New request held high during the DONE cycle -> accepted there, second `md_otp_rdy` 33 cycles later.
  - `rst_n` low mid-DIV -> outputs 0 immediately (asynchronously); after release the unit accepts from IDLE.
